// File: rtl/skid_fifo_if.sv
// Valid/ready channel bundle for skid_fifo: upstream push side and
// downstream pop side. The slave modport is the buffer's view, the master
// modport is the view of whatever drives and consumes it.
interface skid_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/skid_fifo.sv
// Elastic valid/ready buffer of configurable depth. in_ready_o comes from
// flops (gated only by flush/reset), so no combinational path runs from
// out_ready_i back to the upstream side. With REG_OUTPUT=0 an empty buffer
// passes the incoming beat straight through to the output.
module skid_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter bit REG_OUTPUT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  skid_fifo_if.slave                 bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count_ff;
  logic [CW-1:0]         count_nxt;
  logic                  full_ff;
  logic                  empty_ff;
  logic                  blocked;
  logic                  out_valid;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  push_st;
  logic                  pop_st;

  // Pointer increment with an explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Flush and reset both suppress every handshake in the current cycle.
  assign blocked        = flush_i | rst;
  assign bus.in_ready_o = ~full_ff & ~blocked;

  // Stored data has priority; an empty cut-through buffer mirrors the input.
  assign out_valid       = (~empty_ff | (~REG_OUTPUT & bus.in_valid_i)) & ~blocked;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = ~out_valid ? '0 :
                           (empty_ff ? bus.in_data_i : mem[rd_ptr]);

  // A beat that enters and leaves an empty buffer in one cycle never lands
  // in storage; only stored beats move the pointers and the count.
  assign push      = bus.in_valid_i & bus.in_ready_o;
  assign pop       = out_valid & bus.out_ready_i;
  assign bypass    = empty_ff & push & pop;
  assign push_st   = push & ~bypass;
  assign pop_st    = pop & ~empty_ff;
  assign count_nxt = count_ff + CW'(push_st) - CW'(pop_st);

  // Control state: reset and flush both return to the empty state.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_ff <= '0;
      full_ff  <= 1'b0;
      empty_ff <= 1'b1;
    end else begin
      if (push_st) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_st)  rd_ptr <= ptr_inc(rd_ptr);
      count_ff <= count_nxt;
      full_ff  <= (count_nxt == COUNT_MAX);
      empty_ff <= (count_nxt == '0);
    end
  end

  // Payload storage, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_st) mem[wr_ptr] <= bus.in_data_i;
  end

  assign count_o = count_ff;
  assign full_o  = full_ff;
  assign empty_o = empty_ff;
endmodule

// File: tb/tb_skid_fifo.sv
// Bench for skid_fifo: three instances (depth 4 registered, depth 4
// cut-through, depth 3 registered) driven one at a time, checked against a
// queue model of the buffer contents.
module tb_skid_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       drv_flush = 1'b0;
  logic       drv_valid = 1'b0;
  logic       drv_ready = 1'b0;
  logic [7:0] drv_data  = 8'h00;
  int         sel = 0;
  string      phase = "init";
  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  logic [7:0] fill_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  skid_fifo_if #(.DATA_WIDTH(8)) bus0();
  skid_fifo_if #(.DATA_WIDTH(8)) bus1();
  skid_fifo_if #(.DATA_WIDTH(8)) bus2();

  logic       f0, f1, f2;
  logic [2:0] c0, c1;
  logic [1:0] c2;
  logic       fu0, fu1, fu2, em0, em1, em2;

  assign f0 = (sel == 0) & drv_flush;
  assign f1 = (sel == 1) & drv_flush;
  assign f2 = (sel == 2) & drv_flush;
  assign bus0.in_valid_i  = (sel == 0) & drv_valid;
  assign bus1.in_valid_i  = (sel == 1) & drv_valid;
  assign bus2.in_valid_i  = (sel == 2) & drv_valid;
  assign bus0.out_ready_i = (sel == 0) & drv_ready;
  assign bus1.out_ready_i = (sel == 1) & drv_ready;
  assign bus2.out_ready_i = (sel == 2) & drv_ready;
  assign bus0.in_data_i   = drv_data;
  assign bus1.in_data_i   = drv_data;
  assign bus2.in_data_i   = drv_data;

  skid_fifo #(.DATA_WIDTH(8), .DEPTH(4), .REG_OUTPUT(1'b1)) u_reg4 (
    .clk(clk), .rst(rst), .flush_i(f0), .bus(bus0),
    .count_o(c0), .full_o(fu0), .empty_o(em0));
  skid_fifo #(.DATA_WIDTH(8), .DEPTH(4), .REG_OUTPUT(1'b0)) u_cut4 (
    .clk(clk), .rst(rst), .flush_i(f1), .bus(bus1),
    .count_o(c1), .full_o(fu1), .empty_o(em1));
  skid_fifo #(.DATA_WIDTH(8), .DEPTH(3), .REG_OUTPUT(1'b1)) u_reg3 (
    .clk(clk), .rst(rst), .flush_i(f2), .bus(bus2),
    .count_o(c2), .full_o(fu2), .empty_o(em2));

  logic       obs_ir, obs_ov, obs_full, obs_empty;
  logic [7:0] obs_od;
  logic [2:0] obs_count;

  always_comb begin
    obs_ir = bus0.in_ready_o; obs_ov = bus0.out_valid_o; obs_od = bus0.out_data_o;
    obs_count = c0; obs_full = fu0; obs_empty = em0;
    case (sel)
      1: begin
        obs_ir = bus1.in_ready_o; obs_ov = bus1.out_valid_o; obs_od = bus1.out_data_o;
        obs_count = c1; obs_full = fu1; obs_empty = em1;
      end
      2: begin
        obs_ir = bus2.in_ready_o; obs_ov = bus2.out_valid_o; obs_od = bus2.out_data_o;
        obs_count = {1'b0, c2}; obs_full = fu2; obs_empty = em2;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; drv_valid = 1'b1; drv_ready = 1'b1; drv_flush = 1'b0; drv_data = 8'hEE;
    @(posedge clk); #3;
    chk("rst_in_ready", 32'(obs_ir), 0);
    chk("rst_out_valid", 32'(obs_ov), 0);
    @(posedge clk); #1;
    rst = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0;
    q.delete();
    #1;
    chk("post_rst_in_ready", 32'(obs_ir), 1);
    chk("post_rst_out_valid", 32'(obs_ov), 0);
    chk("post_rst_out_data", 32'(obs_od), 0);
    chk("post_rst_count", 32'(obs_count), 0);
    chk("post_rst_full", 32'(obs_full), 0);
    chk("post_rst_empty", 32'(obs_empty), 1);
  endtask

  // One clock cycle with the inputs the caller set; acc reports whether the
  // model expects the presented beat to be taken.
  task automatic step(output bit acc);
    int         depth;
    bit         cut, push, pop, was_empty;
    logic       exp_ir, exp_ov;
    logic [7:0] exp_od;
    depth = (sel == 2) ? 3 : 4;
    cut   = (sel == 1);
    #2;
    exp_ir = (q.size() < depth) && !drv_flush;
    exp_ov = !drv_flush && (q.size() > 0 || (cut && drv_valid));
    exp_od = !exp_ov ? 8'h00 : ((q.size() > 0) ? q[0] : drv_data);
    chk("in_ready", 32'(obs_ir), 32'(exp_ir));
    chk("out_valid", 32'(obs_ov), 32'(exp_ov));
    chk("out_data", 32'(obs_od), 32'(exp_od));
    push = drv_valid && exp_ir;
    pop  = exp_ov && drv_ready;
    acc  = push;
    @(posedge clk);
    if (drv_flush) begin
      q.delete();
    end else begin
      was_empty = (q.size() == 0);
      if (pop && !was_empty) void'(q.pop_front());
      if (push && !(was_empty && pop)) q.push_back(drv_data);
    end
    #1;
    chk("count", 32'(obs_count), 32'(q.size()));
    chk("full", 32'(obs_full), 32'(q.size() == depth));
    chk("empty", 32'(obs_empty), 32'(q.size() == 0));
  endtask

  task automatic rand_run(input int n);
    bit holding, acc;
    holding = 1'b0;
    for (int i = 0; i < n; i++) begin
      drv_valid = holding || ($urandom_range(0, 2) != 0);
      if (!holding) drv_data = 8'($urandom);
      drv_ready = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
      if (i % 10 < 3) drv_ready = 1'b0;
      step(acc);
      holding = drv_valid && !acc;
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    for (int i = 0; i < 5; i++) step(acc);
    chk("drained_empty", 32'(obs_empty), 1);
  endtask

  initial begin
    bit acc;

    // Fill to full with the consumer stalled, then drain in order.
    sel = 0; phase = "fill_drain";
    do_reset();
    drv_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv_valid = 1'b1; drv_data = fill_d[i];
      step(acc);
      chk("fill_count", 32'(obs_count), 32'(i + 1));
    end
    chk("fill_full", 32'(obs_full), 1);
    drv_valid = 1'b0;
    step(acc);
    drv_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(acc);
    chk("drain_empty", 32'(obs_empty), 1);

    // Streaming with both sides active.
    phase = "stream";
    do_reset();
    drv_valid = 1'b1; drv_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drv_data = 8'(i + 1);
      step(acc);
      chk("stream_count", 32'(obs_count), 1);
    end
    drv_valid = 1'b0;
    step(acc);

    // Full buffer with push and pop requested together.
    phase = "full_pop";
    do_reset();
    drv_ready = 1'b0; drv_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv_data = 8'(8'h50 + i);
      step(acc);
    end
    drv_data = 8'h99; drv_ready = 1'b1;
    step(acc);
    chk("full_pop_count", 32'(obs_count), 3);
    drv_ready = 1'b0;
    step(acc);
    chk("refill_count", 32'(obs_count), 4);
    drv_valid = 1'b0; drv_ready = 1'b1;
    for (int i = 0; i < 5; i++) step(acc);

    // Flush with three beats stored and an upstream beat pending.
    phase = "flush";
    do_reset();
    drv_ready = 1'b0; drv_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_data = 8'(8'h61 + i);
      step(acc);
    end
    drv_flush = 1'b1; drv_data = 8'h64;
    step(acc);
    chk("flush_count", 32'(obs_count), 0);
    chk("flush_empty", 32'(obs_empty), 1);
    drv_flush = 1'b0; drv_data = 8'h77; drv_ready = 1'b1;
    step(acc);
    drv_valid = 1'b0;
    step(acc);
    step(acc);

    // Cut-through: bypass when empty, queue when stalled.
    sel = 1; phase = "cut";
    do_reset();
    drv_valid = 1'b1; drv_data = 8'hA5; drv_ready = 1'b1;
    step(acc);
    chk("bypass_count", 32'(obs_count), 0);
    drv_data = 8'h5A; drv_ready = 1'b0;
    step(acc);
    chk("stall_count", 32'(obs_count), 1);
    drv_data = 8'h3C; drv_ready = 1'b1;
    step(acc);
    drv_valid = 1'b0;
    step(acc);
    step(acc);
    phase = "cut_rand";
    rand_run(60);

    // Depth 3 with random stalls exercises pointer wrap.
    sel = 2; phase = "d3_rand";
    do_reset();
    rand_run(80);

    sel = 0; phase = "d4_rand";
    do_reset();
    rand_run(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
